regs_writer: RTL and testbench
==============================

REGS_WRITER -- requirements
Module: regs_writer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; the value SHALL be a power of two and at least 2.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  a result is offered on the in_* inputs.
REQ-005 in_ready  output  1  the block can accept a result this cycle.
REQ-006 in_pair  input  1  1 = 16-bit register-pair write, 0 = 8-bit single write.
REQ-007 in_addr  input  3  target register; encoding B=0, C=1, D=2, E=3, H=4, L=5, 6, A=7.
REQ-008 in_data  input  16  write data; single writes use only [7:0].
REQ-009 hold  input  1  when 1, no entries are drained.
REQ-010 wen0..wen3  output  1 each  register-file write enables.
REQ-011 waddr0..waddr3  output  3 each  register-file write addresses.
REQ-012 wdata0..wdata3  output  8 each  register-file write data.
REQ-013 busy  output  8  bit r = 1 while any FIFO entry targets register r.
REQ-014 count  output  clog2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-015 The block SHALL accept an entry on a rising edge where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH, independent of hold and of a drain in the same cycle.
REQ-017 For a pair entry, in_addr[0] SHALL be ignored: the high byte in_data[15:8] goes to {in_addr[2:1],0} and the low byte in_data[7:0] goes to {in_addr[2:1],1}.
REQ-018 Each cycle with hold=0, the block SHALL drain min(count,2) entries from the FIFO head, oldest first.
REQ-019 The oldest drained entry SHALL drive ports 0/1 and the second-oldest SHALL drive ports 2/3.
REQ-020 For a single entry, port 2k SHALL carry the byte and port 2k+1 SHALL be disabled.
REQ-021 For a pair entry, port 2k SHALL carry the high byte and port 2k+1 SHALL carry the low byte.
REQ-022 Ports SHALL be driven from FIFO storage during the cycle before the draining edge; the register file captures the write on that edge.
REQ-023 Latency: an entry accepted at edge N SHALL be visible on the ports in cycle N+1 and written at edge N+1, if hold=0.
REQ-024 Port priority SHALL be port 3 > 2 > 1 > 0 on an address collision, so the younger entry's value persists.
REQ-025 The block SHALL NOT suppress colliding writes.
REQ-026 When hold=1 or count=0, all wen SHALL be 0 and the FIFO SHALL be unchanged apart from any push.
REQ-027 count SHALL update as count + push - drained, allowing push and drain in the same cycle.
REQ-028 Push while full SHALL NOT occur, because in_ready=0; in_valid without in_ready SHALL be ignored.
REQ-029 busy SHALL be combinational from FIFO contents, including entries being driven this cycle, and SHALL clear after the draining edge.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH without a bubble.
REQ-031 waddr and wdata SHALL be don't-care when the corresponding wen is 0.

Reset
REQ-032 While rst=1, the block SHALL hold: count=0, pointers=0, wen0..3=0, busy=0x00, in_ready=1.
REQ-033 Assertion of rst mid-operation SHALL discard all pending entries immediately, with no further writes issued.
REQ-034 Storage contents SHALL need no reset.

Verification
REQ-035 Single write: push single A=0x5A with hold=0 -> next cycle wen0=1, waddr0=7, wdata0=0x5A, wen1..3=0; busy=0x80 for one cycle, then 0x00.
REQ-036 Pair write: push pair in_addr=5, data 0x1234 -> wen0/wen1=1, waddr0=4/wdata0=0x12, waddr1=5/wdata1=0x34.
REQ-037 Dual drain with collision:
- Stimulus: hold=1, push single B=0x11, then pair BC=0xAABB; release hold.
- Response: in one cycle, port0 writes B=0x11, port2 writes B=0xAA, port3 writes C=0xBB; final B=0xAA.
REQ-038 Full/backpressure: with hold=1, push DEPTH entries -> count=DEPTH, in_ready=0, further in_valid ignored; release hold -> 2 drained per cycle, in_ready=1 after the first drain edge.
REQ-039 Simultaneous push and drain with count=1 -> count stays 1; pointer wrap exercised over more than 2*DEPTH pushes with in-order data.
REQ-040 Reset mid-operation: assert rst with count=3 -> wen0..3 drop to 0 immediately, count=0, busy=0x00, no writes after release until a new push.

Source files
------------

// File: rtl/regs_writer.sv
// Writeback FIFO for register-file results: buffers byte/pair writes and drains
// up to two entries per cycle onto four byte-wide register-file write ports.

module regs_writer_lane (
  input  logic            en,
  input  logic            pair,
  input  logic [2:0]      addr,
  input  logic [15:0]     data,
  output logic [1:0]      wen,
  output logic [1:0][2:0] waddr,
  output logic [1:0][7:0] wdata
);
  // Lower port carries the single byte, or the high byte of a pair.
  assign wen      = {en & pair, en};
  assign waddr[0] = pair ? {addr[2:1], 1'b0} : addr;
  assign waddr[1] = {addr[2:1], 1'b1};
  assign wdata[0] = pair ? data[15:8] : data[7:0];
  assign wdata[1] = data[7:0];
endmodule

module regs_writer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_pair,
  input  logic [2:0]               in_addr,
  input  logic [15:0]              in_data,
  input  logic                     hold,
  output logic                     wen0,
  output logic                     wen1,
  output logic                     wen2,
  output logic                     wen3,
  output logic [2:0]               waddr0,
  output logic [2:0]               waddr1,
  output logic [2:0]               waddr2,
  output logic [2:0]               waddr3,
  output logic [7:0]               wdata0,
  output logic [7:0]               wdata1,
  output logic [7:0]               wdata2,
  output logic [7:0]               wdata3,
  output logic [7:0]               busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int LANES = 2;

  typedef struct packed {
    logic        pair;
    logic [2:0]  addr;
    logic [15:0] data;
  } entry_t;

  entry_t                      mem [DEPTH];
  logic [AW-1:0]               rd_ptr, wr_ptr;
  logic                        push;
  logic [1:0]                  drain_n;
  entry_t [LANES-1:0]          head;
  logic [LANES-1:0]            lane_en;
  logic [LANES-1:0][1:0]       l_wen;
  logic [LANES-1:0][1:0][2:0]  l_addr;
  logic [LANES-1:0][1:0][7:0]  l_data;
  logic [AW-1:0]               off;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready;

  // Lane g drains the g-th oldest entry when at least g+1 entries are held.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign head[g]    = mem[rd_ptr + AW'(g)];
    assign lane_en[g] = !hold && (count > CW'(g));
    regs_writer_lane u_lane (
      .en    (lane_en[g]),
      .pair  (head[g].pair),
      .addr  (head[g].addr),
      .data  (head[g].data),
      .wen   (l_wen[g]),
      .waddr (l_addr[g]),
      .wdata (l_data[g])
    );
  end

  assign drain_n = {1'b0, lane_en[0]} + {1'b0, lane_en[1]};

  assign {wen1, wen0}     = l_wen[0];
  assign {wen3, wen2}     = l_wen[1];
  assign {waddr1, waddr0} = l_addr[0];
  assign {waddr3, waddr2} = l_addr[1];
  assign {wdata1, wdata0} = l_data[0];
  assign {wdata3, wdata2} = l_data[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(drain_n);
      count  <= count + CW'(push) - CW'(drain_n);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pair: in_pair, addr: in_addr, data: in_data};
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    busy = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (CW'(off) < count) begin
        if (mem[i].pair) begin
          busy[{mem[i].addr[2:1], 1'b0}] = 1'b1;
          busy[{mem[i].addr[2:1], 1'b1}] = 1'b1;
        end else begin
          busy[mem[i].addr] = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regs_writer.sv
// Directed bench for regs_writer: register-file model plus hand-computed port
// values for single, pair, collision, backpressure, wrap and reset cases.

module tb_regs_writer;
  localparam int DEPTH = 4;

  logic        clk, rst;
  logic        in_valid, in_ready, in_pair, hold;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        wen0, wen1, wen2, wen3;
  logic [2:0]  waddr0, waddr1, waddr2, waddr3;
  logic [7:0]  wdata0, wdata1, wdata2, wdata3;
  logic [7:0]  busy;
  logic [2:0]  count;
  logic [7:0]  rf [8];
  int          checks, errors;

  regs_writer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .wen0(wen0), .wen1(wen1), .wen2(wen2), .wen3(wen3),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .busy(busy), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model; later ports win on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      if (wen0) rf[waddr0] <= wdata0;
      if (wen1) rf[waddr1] <= wdata1;
      if (wen2) rf[waddr2] <= wdata2;
      if (wen3) rf[waddr3] <= wdata3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic p, input logic [2:0] a, input logic [15:0] d);
    in_valid = v; in_pair = p; in_addr = a; in_data = d;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; hold = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_wen", {wen3, wen2, wen1, wen0}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;
    step();

    // Single write to A
    drive(1'b1, 1'b0, 3'd7, 16'h005A);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    chk("s_wen0", wen0, 1);
    chk("s_waddr0", waddr0, 7);
    chk("s_wdata0", wdata0, 8'h5A);
    chk("s_wen123", {wen3, wen2, wen1}, 0);
    chk("s_busy", busy, 8'h80);
    chk("s_count", count, 1);
    step();
    chk("s_busy_clr", busy, 0);
    chk("s_wen0_off", wen0, 0);
    chk("s_count0", count, 0);
    chk("s_rfA", rf[7], 8'h5A);

    // Pair write to HL (addr 5, bit 0 ignored)
    drive(1'b1, 1'b1, 3'd5, 16'h1234);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    chk("p_wen01", {wen1, wen0}, 2'b11);
    chk("p_wen23", {wen3, wen2}, 2'b00);
    chk("p_waddr0", waddr0, 4);
    chk("p_wdata0", wdata0, 8'h12);
    chk("p_waddr1", waddr1, 5);
    chk("p_wdata1", wdata1, 8'h34);
    chk("p_busy", busy, 8'h30);
    step();
    chk("p_rfH", rf[4], 8'h12);
    chk("p_rfL", rf[5], 8'h34);

    // Dual drain with collision on B
    hold = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 16'h0011);
    step();
    drive(1'b1, 1'b1, 3'd0, 16'hAABB);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    chk("c_count", count, 2);
    chk("c_hold_wen", {wen3, wen2, wen1, wen0}, 0);
    chk("c_busy", busy, 8'h03);
    hold = 1'b0;
    #1;
    chk("c_wen", {wen3, wen2, wen1, wen0}, 4'b1101);
    chk("c_p0", {waddr0, wdata0}, {3'd0, 8'h11});
    chk("c_p2", {waddr2, wdata2}, {3'd0, 8'hAA});
    chk("c_p3", {waddr3, wdata3}, {3'd1, 8'hBB});
    step();
    chk("c_count0", count, 0);
    chk("c_rfB", rf[0], 8'hAA);
    chk("c_rfC", rf[1], 8'hBB);

    // Fill to DEPTH under hold, then extra offers must be ignored
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 3'd2, 16'(i + 1));
      step();
    end
    chk("f_count", count, DEPTH);
    chk("f_ready", in_ready, 0);
    drive(1'b1, 1'b0, 3'd2, 16'h00EE);
    step(); step();
    chk("f_count_hold", count, DEPTH);
    chk("f_ready_hold", in_ready, 0);
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    hold = 1'b0;
    #1;
    chk("f_d0", {wen2, wen0, wdata2, wdata0}, {2'b11, 8'h02, 8'h01});
    step();
    chk("f_count2", count, 2);
    chk("f_ready2", in_ready, 1);
    chk("f_d1", {wen2, wen0, wdata2, wdata0}, {2'b11, 8'h04, 8'h03});
    step();
    chk("f_count0", count, 0);
    chk("f_rfD", rf[2], 8'h04);

    // Streaming push+drain at count=1, wraps pointers several times
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 3'd3, 16'(k + 8'h30));
      step();
      chk("w_count", count, 1);
      chk("w_wen", {wen2, wen0}, 2'b01);
      chk("w_data", wdata0, k + 8'h30);
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    step();
    chk("w_count0", count, 0);
    chk("w_rfE", rf[3], 8'h39);

    // Reset with three pending entries
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'd6, 16'(i + 8'h70));
      step();
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000);
    chk("r_count3", count, 3);
    hold = 1'b0;
    #1;
    chk("r_wen_pre", {wen2, wen0}, 2'b11);
    rst = 1'b1;
    #1;
    chk("r_wen", {wen3, wen2, wen1, wen0}, 0);
    chk("r_count", count, 0);
    chk("r_busy", busy, 0);
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("r_wen_after", {wen3, wen2, wen1, wen0}, 0);
    chk("r_count_after", count, 0);
    chk("r_rf6", rf[6], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
